button_pulse_gen: RTL and testbench

//  Conditions one raw active-low board pushbutton (move or select) into clean control strobes for the game

---
 rtl/button_pulse_gen.sv | 150 +++++++++++++++
 tb/tb_button_pulse_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_gen.sv
// Conditions one raw active-low pushbutton into a debounced level, a one-cycle press strobe
// and optional auto-repeat strobes while the button is held.
module button_pulse_gen #(
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_RATE   = 10000000,
    parameter bit          REPEAT_EN     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pulse,
    output logic pressed,
    output logic long_press
);

    localparam int unsigned MaxSR  = (STABLE_CYCLES > REPEAT_RATE) ? STABLE_CYCLES : REPEAT_RATE;
    localparam int unsigned MaxCnt = (MaxSR > REPEAT_DELAY) ? MaxSR : REPEAT_DELAY;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] Zero     = '0;
    localparam logic [CntW-1:0] One      = CntW'(1);
    localparam logic [CntW-1:0] Stable   = CntW'(STABLE_CYCLES);
    localparam logic [CntW-1:0] StableM1 = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] Delay    = CntW'(REPEAT_DELAY);
    localparam logic [CntW-1:0] DelayM1  = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RateM1   = CntW'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {StArm, StReleased, StPressChk, StPressed, StRelChk} state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic            btn_s;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] hcnt_q, hcnt_d;
    logic [CntW-1:0] rcnt_q, rcnt_d;
    logic            pulse_d, pressed_d, long_d;

    assign btn_s = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= 2'b11;
            state_q    <= StArm;
            cnt_q      <= Zero;
            hcnt_q     <= Zero;
            rcnt_q     <= Zero;
            pulse      <= 1'b0;
            pressed    <= 1'b0;
            long_press <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_n};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            rcnt_q     <= rcnt_d;
            pulse      <= pulse_d;
            pressed    <= pressed_d;
            long_press <= long_d;
        end
    end

    // cnt only ever climbs to Stable before a state change resets it, so it cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        long_d  = long_press;
        unique case (state_q)
            StArm: begin
                if (!btn_s) begin
                    cnt_d = Zero;
                end else if (cnt_q >= StableM1) begin
                    state_d = StReleased;
                    cnt_d   = Zero;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            StReleased: begin
                if (!btn_s) begin
                    state_d = StPressChk;
                    cnt_d   = One;
                end else begin
                    cnt_d = Zero;
                end
            end
            StPressChk: begin
                if (btn_s) begin
                    state_d = StReleased;
                    cnt_d   = Zero;
                end else if (cnt_q >= Stable) begin
                    state_d = StPressed;
                    cnt_d   = Zero;
                    hcnt_d  = Zero;
                    rcnt_d  = Zero;
                    long_d  = 1'b0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            StPressed: begin
                if (btn_s) begin
                    state_d = StRelChk;
                    cnt_d   = One;
                end else if (hcnt_q < Delay) begin
                    cnt_d  = Zero;
                    hcnt_d = hcnt_q + One;
                    if (hcnt_q == DelayM1) begin
                        long_d  = 1'b1;
                        pulse_d = REPEAT_EN;
                        rcnt_d  = Zero;
                    end
                end else begin
                    // hcnt saturated: free-running repeat phase
                    cnt_d = Zero;
                    if (rcnt_q >= RateM1) begin
                        rcnt_d  = Zero;
                        pulse_d = REPEAT_EN;
                    end else begin
                        rcnt_d = rcnt_q + One;
                    end
                end
            end
            StRelChk: begin
                if (!btn_s) begin
                    state_d = StPressed;
                    cnt_d   = Zero;
                end else if (cnt_q >= Stable) begin
                    state_d = StReleased;
                    cnt_d   = Zero;
                    hcnt_d  = Zero;
                    rcnt_d  = Zero;
                    long_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            default: begin
                state_d = StArm;
                cnt_d   = Zero;
            end
        endcase
        pressed_d = (state_d == StPressed) || (state_d == StRelChk);
    end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: two instances (repeat off / on) driven by one button, checked
// every cycle against a run-length reference model plus targeted latency checks.
module tb_button_pulse_gen;

    localparam int STABLE = 4;
    localparam int DELAY  = 12;
    localparam int RATE   = 3;

    logic clk;
    logic rst;
    logic btn_n;
    logic pulse0, pressed0, long0;
    logic pulse1, pressed1, long1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_s1, m_s2, m_armed, m_run_val, m_level;
    int m_run_len, m_h;
    bit exp_pulse0, exp_pulse1, exp_pressed, exp_long;

    logic [5:0] got, want;
    assign got  = {pulse0, pressed0, long0, pulse1, pressed1, long1};
    assign want = {exp_pulse0, exp_pressed, exp_long, exp_pulse1, exp_pressed, exp_long};

    button_pulse_gen #(
        .STABLE_CYCLES(STABLE), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .REPEAT_EN(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .pulse(pulse0), .pressed(pressed0), .long_press(long0)
    );

    button_pulse_gen #(
        .STABLE_CYCLES(STABLE), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .REPEAT_EN(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .pulse(pulse1), .pressed(pressed1), .long_press(long1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1;
        m_armed = 1'b0; m_run_val = 1'b1; m_run_len = 0;
        m_level = 1'b0; m_h = 0;
        exp_pulse0 = 1'b0; exp_pulse1 = 1'b0; exp_pressed = 1'b0; exp_long = 1'b0;
    endtask

    // The debounced level flips once the synced input has disagreed with it for STABLE+1
    // consecutive samples; hold time counts only samples spent pressed with no release pending.
    task automatic model_step();
        bit s;
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_n;
        exp_pulse0 = 1'b0;
        exp_pulse1 = 1'b0;
        if (s == m_run_val) m_run_len++;
        else begin
            m_run_val = s;
            m_run_len = 1;
        end
        if (!m_armed) begin
            if (s && m_run_len >= STABLE) m_armed = 1'b1;
        end else if (!m_level) begin
            if (!s && m_run_len == STABLE + 1) begin
                m_level = 1'b1; m_h = 0; exp_pulse0 = 1'b1; exp_pulse1 = 1'b1;
            end
        end else if (s) begin
            if (m_run_len == STABLE + 1) begin
                m_level = 1'b0; m_h = 0;
            end
        end else if (m_run_len >= 2) begin
            m_h++;
            if (m_h == DELAY) exp_pulse1 = 1'b1;
            else if (m_h > DELAY && (m_h - DELAY) % RATE == 0) exp_pulse1 = 1'b1;
        end
        exp_pressed = m_level;
        exp_long    = m_level && (m_h >= DELAY);
    endtask

    task automatic tick(input bit b);
        btn_n = b;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input bit b);
        btn_n = b;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", got, 6'b0);
        end
    endtask

    task automatic test_clean_press();
        int first = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL clean_idle cyc %0d: got %b want %b", i, got, want);
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL clean_press cyc %0d: got %b want %b", i, got, want);
            end
            if (pulse0 && first < 0) first = i;
        end
        checks++;
        if (first != 6) begin
            errors++; $display("FAIL clean_press_latency: got edge %0d want edge 6", first);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL clean_release cyc %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_glitch_press();
        int seen = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 9; i++) begin
                tick(i < 3 ? 1'b0 : 1'b1);
                checks++;
                if (got !== want) begin
                    errors++; $display("FAIL glitch_press r%0d cyc %0d: got %b want %b", r, i, got, want);
                end
                if (pulse0 || pulse1 || pressed0 || pressed1) seen++;
            end
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL glitch_press_reject: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_held_reset();
        int np = 0;
        do_reset(1'b0);
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL held_reset cyc %0d: got %b want %b", i, got, want);
            end
            if (pulse0 || pulse1) np++;
        end
        checks++;
        if (np != 0) begin
            errors++; $display("FAIL held_reset_nopulse: got %0d pulses want 0", np);
        end
        for (int i = 0; i < 10; i++) tick(1'b1);
        np = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL held_repress cyc %0d: got %b want %b", i, got, want);
            end
            if (pulse0) np++;
        end
        checks++;
        if (np != 1) begin
            errors++; $display("FAIL held_repress_count: got %0d pulses want 1", np);
        end
        for (int i = 0; i < 10; i++) tick(1'b1);
    endtask

    task automatic test_repeat();
        logic [29:0] obs_mask = '0;
        logic [29:0] exp_mask = '0;
        int first_long = -1;
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b0);
            if (pulse1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL repeat_accept: got no press strobe want one within 20 cycles");
        end
        for (int off = 0; off < 30; off++) begin
            if (off > 0) tick(1'b0);
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL repeat cyc %0d: got %b want %b", off, got, want);
            end
            obs_mask[off] = pulse1;
            if (long1 && first_long < 0) first_long = off;
            exp_mask[off] = (off == 0) || (off >= DELAY && (off - DELAY) % RATE == 0);
        end
        checks++;
        if (obs_mask !== exp_mask) begin
            errors++; $display("FAIL repeat_pattern: got %b want %b", obs_mask, exp_mask);
        end
        checks++;
        if (first_long != DELAY) begin
            errors++; $display("FAIL long_press_start: got %0d want %0d", first_long, DELAY);
        end
    endtask

    task automatic test_glitch_hold();
        int drops = 0;
        int fall = -1;
        for (int i = 0; i < 7; i++) begin
            tick(i < 2 ? 1'b1 : 1'b0);
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL glitch_hold cyc %0d: got %b want %b", i, got, want);
            end
            if (!pressed0 || pulse0) drops++;
        end
        checks++;
        if (drops != 0) begin
            errors++; $display("FAIL glitch_hold_level: got %0d bad cycles want 0", drops);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL hold_release cyc %0d: got %b want %b", i, got, want);
            end
            if (!pressed0 && fall < 0) fall = i;
        end
        checks++;
        if (fall != 6) begin
            errors++; $display("FAIL release_latency: got edge %0d want edge 6", fall);
        end
    endtask

    task automatic test_reset_presschk();
        int np = 0;
        for (int i = 0; i < 8; i++) tick(1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0);
        #3 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (got !== 6'b0) begin
            errors++; $display("FAIL async_reset_outputs: got %b want %b", got, 6'b0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL post_reset_hold cyc %0d: got %b want %b", i, got, want);
            end
            if (pulse0 || pulse1) np++;
        end
        checks++;
        if (np != 0) begin
            errors++; $display("FAIL post_reset_nopulse: got %0d pulses want 0", np);
        end
        for (int i = 0; i < 10; i++) tick(1'b1);
        np = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            if (pulse0) np++;
        end
        checks++;
        if (np != 1) begin
            errors++; $display("FAIL post_reset_repress: got %0d pulses want 1", np);
        end
        for (int i = 0; i < 10; i++) tick(1'b1);
    endtask

    task automatic test_random();
        int cyc = 0;
        do_reset(1'b1);
        while (cyc < 800) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                              : int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                tick(lvl);
                checks++;
                if (got !== want) begin
                    errors++; $display("FAIL random cyc %0d: got %b want %b", cyc, got, want);
                end
                cyc++;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        btn_n = 1'b1;
        model_reset();
        test_reset();
        test_clean_press();
        test_glitch_press();
        test_held_reset();
        test_repeat();
        test_glitch_hold();
        test_reset_presschk();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
